// File: rtl/uart_loader.sv
// uart_loader -- serial boot loader for the tiny16 core.
//
// Receives a program image over an 8N1 UART line and writes it into memory
// as 16-bit words. Image format (all fields big-endian):
//   count[15:8], count[7:0], then count words, each sent as hi byte, lo byte.
// The core is held in reset (cpu_hold) until the last word has been written.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous UART receive line, idle high
//   mem_wr_en  single-cycle memory write strobe
//   mem_addr   word address of the current write (holds between writes)
//   mem_data   word to write, valid while mem_wr_en is high
//   cpu_hold   high while loading; falls in the cycle done pulses
//   done       single-cycle pulse when the image is complete
//   frame_err  sticky flag, set on a stop-bit error, cleared only by rst

module uart_loader #(
    parameter int CLKS_PER_BIT = 139,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  frame_err
);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN_HI, L_LEN_LO, L_W_HI, L_W_LO, L_DONE} ld_state_t;

    // Counter terminal values: the start bit is sampled half a bit in, every
    // other bit a full bit after the previous sample.
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic       rx_meta, rxs;
    rx_state_t  r_state, r_state_n;
    logic [15:0] clk_cnt, clk_cnt_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       byte_valid;   // cycle S: a good stop bit was just sampled
    logic       stop_err;     // cycle S: the stop bit was sampled low

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            r_state <= R_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            r_state <= r_state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        r_state_n  = r_state;
        clk_cnt_n  = clk_cnt + 16'd1;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!rxs) r_state_n = R_START;
            end
            R_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    // A high line mid start bit was only a glitch.
                    r_state_n = rxs ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = {rxs, shift[7:1]};   // LSB arrives first
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) r_state_n = R_STOP;
                end
            end
            R_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n  = '0;
                    r_state_n  = R_IDLE;
                    byte_valid = rxs;
                    stop_err   = !rxs;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t             ld_state, ld_state_n;
    logic [15:0]           count, count_n;
    logic [7:0]            hi_byte, hi_byte_n;
    logic [ADDR_WIDTH-1:0] word_idx, word_idx_n, idx_inc;
    logic                  wr_n, done_n, hold_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [15:0]           data_n;

    assign idx_inc = word_idx + 1'b1;

    // NOTE: all loader registers, outputs included, take the synchronous
    // reset; there is no memory array here that should be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state  <= L_LEN_HI;
            count     <= '0;
            hi_byte   <= '0;
            word_idx  <= '0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ld_state  <= ld_state_n;
            count     <= count_n;
            hi_byte   <= hi_byte_n;
            word_idx  <= word_idx_n;
            mem_wr_en <= wr_n;
            mem_addr  <= addr_n;
            mem_data  <= data_n;
            cpu_hold  <= hold_n;
            done      <= done_n;
            if (stop_err) frame_err <= 1'b1;
        end
    end

    always_comb begin
        ld_state_n = ld_state;
        count_n    = count;
        hi_byte_n  = hi_byte;
        word_idx_n = word_idx;
        wr_n       = 1'b0;
        addr_n     = mem_addr;
        data_n     = mem_data;
        done_n     = 1'b0;
        hold_n     = cpu_hold;
        if (stop_err && ld_state != L_DONE) begin
            // A corrupted byte invalidates the image: wait for a new header.
            ld_state_n = L_LEN_HI;
            word_idx_n = '0;
        end else if (byte_valid) begin
            unique case (ld_state)
                L_LEN_HI: begin
                    count_n[15:8] = shift;
                    ld_state_n    = L_LEN_LO;
                end
                L_LEN_LO: begin
                    count_n[7:0] = shift;
                    word_idx_n   = '0;
                    if ({count[15:8], shift} == 16'd0) begin
                        ld_state_n = L_DONE;
                        done_n     = 1'b1;
                        hold_n     = 1'b0;
                    end else begin
                        ld_state_n = L_W_HI;
                    end
                end
                L_W_HI: begin
                    hi_byte_n  = shift;
                    ld_state_n = L_W_LO;
                end
                L_W_LO: begin
                    wr_n       = 1'b1;
                    data_n     = {hi_byte, shift};
                    addr_n     = word_idx;
                    word_idx_n = idx_inc;
                    if (idx_inc == ADDR_WIDTH'(count)) begin
                        ld_state_n = L_DONE;
                        done_n     = 1'b1;
                        hold_n     = 1'b0;
                    end else begin
                        ld_state_n = L_W_HI;
                    end
                end
                L_DONE: ;   // image complete; only rst restarts the loader
                default: ld_state_n = L_LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader. Stimulus drives the UART line on the falling
// clock edge; a reference model turns every sent byte into expected writes
// (queued with their expected cycle) and a monitor compares DUT writes.

module tb_uart_loader;

    localparam int CPB = 4;
    localparam int AW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          cpu_hold;
    logic          done;
    logic          frame_err;

    uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: the image is simply the list of good bytes seen
    // since the last reset or framing error.
    // ------------------------------------------------------------------
    typedef struct {
        int          addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img[$];
    bit         m_done    = 0;
    bit         exp_frame = 0;
    int         exp_done  = 0;
    int         done_seen = 0;

    function automatic void model_byte(input logic [7:0] b, input bit ok, input int now);
        int n;
        int cnt;
        if (m_done) return;
        if (!ok) begin
            exp_frame = 1;
            img.delete();
            return;
        end
        img.push_back(b);
        n = img.size();
        if (n < 2) return;
        cnt = {img[0], img[1]};
        if (n >= 4 && n % 2 == 0)
            exp_q.push_back('{addr: (n - 4) / 2, data: {img[n-2], img[n-1]}, cyc: now + 1});
        if (n == 2 + 2 * cnt) begin
            m_done = 1;
            exp_done++;
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor: checks every write and every done pulse as they happen.
    // ------------------------------------------------------------------
    bit prev_wr   = 0;
    bit prev_hold = 1;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            prev_wr   = 0;
            prev_hold = 1;
        end else begin
            if (mem_wr_en) begin
                check("wr_single_cycle", 32'(prev_wr), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", mem_addr, mem_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_data), 32'(e.data));
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                done_seen++;
                check("hold_before_done", 32'(prev_hold), 32'd1);
                check("hold_at_done", 32'(cpu_hold), 32'd0);
            end
            prev_wr   = mem_wr_en;
            prev_hold = cpu_hold;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (entered and left just after a falling edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        model_byte(b, stop_ok, cyc);
        if (!stop_ok) idle(2 * CPB);
    endtask

    task automatic send_rand_image(input int n);
        logic [15:0] c;
        logic [15:0] w;
        c = 16'(n);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
    endtask

    task automatic do_reset();
        check("pending_before_reset", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        img.delete();
        exp_q.delete();
        m_done    = 0;
        exp_frame = 0;
        exp_done  = 0;
        done_seen = 0;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic end_test(input string name);
        idle(3 * CPB);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_count"}, 32'(done_seen), 32'(exp_done));
        check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!m_done));
        check({name, "_frame_err"}, 32'(frame_err), 32'(exp_frame));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        @(negedge clk);
        do_reset();

        // 1: two-word image
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        end_test("t1");

        // 6: bytes after done are ignored
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        end_test("t6");

        // 2: empty image
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        end_test("t2");

        // 3: one-cycle glitch, then a random image
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        idle(3 * CPB);
        check("t3_no_write_after_glitch", 32'(mem_wr_en), 32'd0);
        send_rand_image(int'($urandom_range(1, 4)));
        end_test("t3");

        // 4: framing error mid-image, then a fresh image
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        send_byte(8'h56, 1'b0);
        check("t4_frame_err_set", 32'(frame_err), 32'd1);
        check("t4_hold_after_err", 32'(cpu_hold), 32'd1);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        end_test("t4");

        // 5: reset in the middle of the third word, then resend
        do_reset();
        begin
            logic [15:0] w[4];
            for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
            send_byte(8'h00); send_byte(8'h04);
            send_byte(w[0][15:8]); send_byte(w[0][7:0]);
            send_byte(w[1][15:8]); send_byte(w[1][7:0]);
            send_byte(w[2][15:8]);
            rx = 1'b0;               // low byte starts, then reset mid-frame
            idle(2 * CPB + 1);
            idle(2);
            check("t5_pending_mid", 32'(exp_q.size()), 32'd0);
            do_reset();
            send_byte(8'h00); send_byte(8'h04);
            for (int i = 0; i < 4; i++) begin
                send_byte(w[i][15:8]);
                send_byte(w[i][7:0]);
            end
        end
        end_test("t5");

        // extra random images
        for (int k = 0; k < 3; k++) begin
            do_reset();
            send_rand_image(int'($urandom_range(1, 6)));
            end_test("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
